// File: rtl/data_line_if.sv
// Opcode handshake plus byte in/out streams between the IP line, data_line and the I/O ports.
interface data_line_if #(
   parameter int unsigned DATA_DEPTH = 32,
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned AP_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

   logic [15:0]           Opcode;
   logic                  OpcodeReady;
   logic                  OpcodeAck;
   logic                  DataZero;
   logic [AP_W-1:0]       Ap;
   logic [DATA_WIDTH-1:0] OutData;
   logic                  OutValid;
   logic                  OutReady;
   logic [DATA_WIDTH-1:0] InData;
   logic                  InValid;
   logic                  InReady;
   logic                  Halted;

   modport master (
      output Opcode, OpcodeReady, OutReady, InData, InValid,
      input  OpcodeAck, DataZero, Ap, OutData, OutValid, InReady, Halted
   );

   modport slave (
      input  Opcode, OpcodeReady, OutReady, InData, InValid,
      output OpcodeAck, DataZero, Ap, OutData, OutValid, InReady, Halted
   );
endinterface

// File: rtl/data_line.sv
// Data-line execution stage: data pointer, cell memory, cell arithmetic, byte I/O and halt.
// Optional BCD_CELLS_EN makes cells two packed BCD digits (requires DATA_WIDTH == 8).
module data_line #(
   parameter int unsigned DATA_DEPTH = 32,
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic        Clk,
   input logic        Rst_n,
   data_line_if.slave bus
);

   localparam int unsigned AP_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam int unsigned OP_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_OUT_WAIT,
      S_IN_WAIT,
      S_ACK,
      S_HALT
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP,
      OP_INC,
      OP_DEC,
      OP_AP_INC,
      OP_AP_DEC,
      OP_LOOP,
      OP_OUT,
      OP_IN,
      OP_HALT
   } op_e;

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic [AP_W-1:0]       ap_q, ap_d;
   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DATA_DEPTH];
   logic                  data_zero_q, data_zero_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  in_ready_q, in_ready_d;
   logic                  halted_q, halted_d;
   logic [DATA_WIDTH-1:0] cell_c;

   // Lowest set bit wins; bit 0, bits 10..15 and all-zero decode to NOP.
   function automatic op_e decode_op(input logic [OP_W-1:0] op);
      op_e kind;
      kind = OP_NOP;
      for (int i = OP_W - 1; i >= 0; i--) begin
         if (op[i]) begin
            case (i)
               1:       kind = OP_INC;
               2:       kind = OP_DEC;
               3:       kind = OP_AP_INC;
               4:       kind = OP_AP_DEC;
               5, 6:    kind = OP_LOOP;
               7:       kind = OP_OUT;
               8:       kind = OP_IN;
               9:       kind = OP_HALT;
               default: kind = OP_NOP;
            endcase
         end
      end
      return kind;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] cell_inc(input logic [DATA_WIDTH-1:0] v);
`ifdef BCD_CELLS_EN
      logic [3:0] lo;
      logic [3:0] hi;
      lo = v[3:0];
      hi = v[7:4];
      if (lo >= 4'd9) begin
         lo = 4'd0;
         hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
      end else begin
         lo = lo + 4'd1;
      end
      return DATA_WIDTH'({hi, lo});
`else
      return v + DATA_WIDTH'(1);
`endif
   endfunction

   function automatic logic [DATA_WIDTH-1:0] cell_dec(input logic [DATA_WIDTH-1:0] v);
`ifdef BCD_CELLS_EN
      logic [3:0] lo;
      logic [3:0] hi;
      lo = v[3:0];
      hi = v[7:4];
      if (lo == 4'd0) begin
         lo = 4'd9;
         hi = (hi == 4'd0) ? 4'd9 : hi - 4'd1;
      end else begin
         lo = lo - 4'd1;
      end
      return DATA_WIDTH'({hi, lo});
`else
      return v - DATA_WIDTH'(1);
`endif
   endfunction

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      ap_d        = ap_q;
      mem_d       = mem_q;
      ack_d       = ack_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      halted_d    = halted_q;
      cell_c      = mem_q[ap_q];
      data_zero_d = (cell_c == '0);

      case (state_q)
         S_IDLE: begin
            if (bus.OpcodeReady && !halted_q) begin
               op_d    = decode_op(bus.Opcode);
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            state_d = S_ACK;
            case (op_q)
               OP_INC:    mem_d[ap_q] = cell_inc(cell_c);
               OP_DEC:    mem_d[ap_q] = cell_dec(cell_c);
               OP_AP_INC: ap_d = (ap_q == AP_W'(DATA_DEPTH - 1)) ? '0 : ap_q + AP_W'(1);
               OP_AP_DEC: ap_d = (ap_q == '0) ? AP_W'(DATA_DEPTH - 1) : ap_q - AP_W'(1);
               OP_OUT: begin
                  out_data_d  = cell_c;
                  out_valid_d = 1'b1;
                  state_d     = S_OUT_WAIT;
               end
               OP_IN: begin
                  in_ready_d = 1'b1;
                  state_d    = S_IN_WAIT;
               end
               OP_HALT: begin
                  halted_d = 1'b1;
                  ack_d    = 1'b1;
                  state_d  = S_HALT;
               end
               default: ;
            endcase
         end

         S_OUT_WAIT: begin
            if (out_valid_q && bus.OutReady) begin
               out_valid_d = 1'b0;
               state_d     = S_ACK;
            end
         end

         S_IN_WAIT: begin
            if (bus.InValid && in_ready_q) begin
               mem_d[ap_q] = bus.InData;
               in_ready_d  = 1'b0;
               state_d     = S_ACK;
            end
         end

         // Ack tracks OpcodeReady; return to IDLE only once the request is withdrawn.
         S_ACK: begin
            ack_d = bus.OpcodeReady;
            if (!bus.OpcodeReady) begin
               state_d = S_IDLE;
            end
         end

         S_HALT: begin
            ack_d = ack_q && bus.OpcodeReady;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_NOP;
         ap_q        <= '0;
         data_zero_q <= 1'b1;
         ack_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         halted_q    <= 1'b0;
         for (int i = 0; i < DATA_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         ap_q        <= ap_d;
         data_zero_q <= data_zero_d;
         ack_q       <= ack_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         halted_q    <= halted_d;
         mem_q       <= mem_d;
      end
   end

   assign bus.OpcodeAck = ack_q;
   assign bus.DataZero  = data_zero_q;
   assign bus.Ap        = ap_q;
   assign bus.OutData   = out_data_q;
   assign bus.OutValid  = out_valid_q;
   assign bus.InReady   = in_ready_q;
   assign bus.Halted    = halted_q;

endmodule
